idma_desc64_reader_gater_q: RTL and testbench
=============================================

IDMA_DESC64_READER_GATER_Q -- requirements
Module: idma_desc64_reader_gater_q

Interface
REQ-001 SHALL have parameter FlushWidth, default 8, width of a flush count (bursts to drop).
REQ-002 SHALL have parameter QueueDepth, default 4, number of queued flush requests; legal range 2..16.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush_cnt_i  in  FlushWidth  number of R bursts to drop.
REQ-006 SHALL have port flush_imm_i  in  1  1 = start dropping at the next burst boundary, 0 = first let the in-flight burst finish.
REQ-007 SHALL have port flush_valid_i / flush_ready_o  in/out  1  request handshake.
REQ-008 SHALL have port r_valid_i, r_ready_i, r_last_i  in  1  upstream valid, downstream ready, last beat of the burst.
REQ-009 SHALL have port r_valid_o, r_ready_o  out  1  gated valid to downstream, ready to upstream.
REQ-010 SHALL have port busy_o  out  1  FSM not IDLE or queue non-empty.
REQ-011 SHALL have port dropped_o  out  1  one-cycle pulse per fully dropped burst.
REQ-012 SHALL have port usage_o  out  $clog2(QueueDepth)+1  queued entry count.

Function
REQ-013 SHALL accept a request when flush_valid_i && flush_ready_o; flush_ready_o = queue not full (registered state, no combinational path from flush_valid_i).
REQ-014 SHALL make a pushed entry visible to the FSM the cycle after the push (no bypass).
REQ-015 SHALL implement FSM states IDLE, ARM, FLUSH; the FSM SHALL act on the queue head only.
REQ-016 IDLE: head cnt==0 -> pop, stay IDLE; head cnt>0 and imm=1 -> pop, load counter, go FLUSH; head cnt>0 and imm=0 -> go ARM (no pop).
REQ-017 ARM: pass-through; on r_valid_i && r_ready_i && r_last_i -> pop head, load counter, go FLUSH next cycle.
REQ-018 FLUSH: r_valid_o=0, r_ready_o=1; on r_valid_i && r_last_i decrement counter and pulse dropped_o same cycle; counter==1 at that event -> IDLE.
REQ-019 IDLE and ARM: r_valid_o=r_valid_i, r_ready_o=r_ready_i (combinational pass-through).
REQ-020 Non-last beats in FLUSH SHALL be consumed silently and not change the counter.
REQ-021 SHALL process entries strictly in FIFO order, at most one pop per cycle.
REQ-022 SHALL permit push and pop in the same cycle; usage_o SHALL then be unchanged.
REQ-023 An imm=1 entry popped while a burst is mid-flight SHALL drop the remaining beats of that burst, and that burst SHALL count as one dropped burst.
REQ-024 Counter width SHALL be FlushWidth; it does not wrap, because it never decrements below 1.

Reset
REQ-025 While rst_i is high: FSM=IDLE, queue empty, counter=0, dropped_o=0, busy_o=0, usage_o=0, flush_ready_o=1, R path pass-through.
REQ-026 Reset asserted mid-FLUSH SHALL abandon the flush and discard all queued entries.

Structure
REQ-027 SHALL place the FSM state enum and the entry struct {imm, cnt} in package idma_desc64_pkg.
REQ-028 SHALL implement the queue with common_cells fifo_v3 (FALL_THROUGH=0, DEPTH=QueueDepth), with rst_ni driven by !rst_i.
REQ-029 SHALL carry a non-synthesised assertion that QueueDepth is in 2..16.

Verification
REQ-030 Push {imm=0, cnt=2} during beat 2 of a 4-beat burst -> that burst passes intact; next 2 bursts dropped with r_ready_o=1; 2 dropped_o pulses; the 4th burst passes.
REQ-031 Push {imm=1, cnt=1} while R is idle -> FLUSH the following cycle; next burst dropped; back to IDLE.
REQ-032 Push {0,0}, then {0,1} -> first entry popped with no effect; one burst passed, then one dropped.
REQ-033 Push 4 entries back-to-back with Depth=4 -> flush_ready_o=0 after the 4th; a 5th request stalls until the first pop; usage_o goes 1,2,3,4.
REQ-034 Assert rst_i for 1 cycle mid-FLUSH with 2 entries queued -> outputs pass-through next cycle, usage_o=0, no dropped_o pulses.
REQ-035 Random back-pressure on r_ready_i with a 0.5 duty cycle -> no beat is duplicated or lost, and no output valid is dropped in pass-through.

Source files
------------

// File: rtl/idma_desc64_pkg.sv
// Shared types for the iDMA 64-bit descriptor reader R-channel gater.
//   gater_state_e : gater FSM states
//   flush_entry_t : one queued flush request {imm, cnt}
// FLUSH_W_MAX bounds the count field stored in the queue. The gater zero-extends
// its FlushWidth-wide count into this field and truncates it back on read.
package idma_desc64_pkg;

  localparam int unsigned FLUSH_W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FLUSH = 2'd2
  } gater_state_e;

  typedef struct packed {
    logic                   imm;
    logic [FLUSH_W_MAX-1:0] cnt;
  } flush_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO, interface-compatible with common_cells fifo_v3.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   flush_i           : synchronous clear of all entries
//   testmode_i        : unused, kept for interface compatibility
//   full_o, empty_o   : status
//   usage_o           : fill level (wraps to 0 when full at power-of-two depth)
//   data_i/push_i     : write side, ignored when full
//   data_o/pop_i      : read side (head), ignored when empty
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam int unsigned FIFO_DEPTH = (DEPTH > 0) ? DEPTH : 1;

  logic [ADDR_DEPTH-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_n, w_wr_ptr_n;
  logic [ADDR_DEPTH:0]   r_status_cnt, w_status_cnt_n;
  logic                  w_we;
  logic                  w_unused_testmode;
  dtype                  r_mem [FIFO_DEPTH];

  assign w_unused_testmode = testmode_i;

  function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
    if (p == ADDR_DEPTH'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (r_status_cnt == (ADDR_DEPTH+1)'(FIFO_DEPTH));
  assign empty_o = (r_status_cnt == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = r_status_cnt[ADDR_DEPTH-1:0];

  always_comb begin
    w_rd_ptr_n     = r_rd_ptr;
    w_wr_ptr_n     = r_wr_ptr;
    w_status_cnt_n = r_status_cnt;
    w_we           = 1'b0;
    data_o         = r_mem[r_rd_ptr];

    if (push_i && !full_o) begin
      w_we           = 1'b1;
      w_wr_ptr_n     = ptr_inc(r_wr_ptr);
      w_status_cnt_n = r_status_cnt + 1'b1;
    end

    if (pop_i && !empty_o) begin
      w_rd_ptr_n = ptr_inc(r_rd_ptr);
      // A simultaneous push and pop leaves the fill level unchanged.
      if (push_i && !full_o) w_status_cnt_n = r_status_cnt;
      else                   w_status_cnt_n = r_status_cnt - 1'b1;
    end

    // Fall-through: an empty FIFO forwards the incoming word directly.
    if (FALL_THROUGH && (r_status_cnt == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        w_status_cnt_n = r_status_cnt;
        w_rd_ptr_n     = r_rd_ptr;
        w_wr_ptr_n     = r_wr_ptr;
        w_we           = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_status_cnt <= '0;
    end else if (flush_i) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_status_cnt <= '0;
    end else begin
      r_rd_ptr     <= w_rd_ptr_n;
      r_wr_ptr     <= w_wr_ptr_n;
      r_status_cnt <= w_status_cnt_n;
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/idma_desc64_reader_gater_q.sv
// R-channel gater with a queue of flush requests. Each request drops a number
// of whole R bursts, either at the next burst boundary (imm=1) or after the
// in-flight burst has completed (imm=0).
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   flush_cnt_i, flush_imm_i     : request payload (bursts to drop, immediacy)
//   flush_valid_i/flush_ready_o  : request handshake
//   r_valid_i, r_ready_i, r_last_i : upstream valid, downstream ready, last beat
//   r_valid_o, r_ready_o         : gated valid downstream, ready upstream
//   busy_o                       : FSM active or requests pending
//   dropped_o                    : one-cycle pulse per dropped burst
//   usage_o                      : number of queued requests
module idma_desc64_reader_gater_q
  import idma_desc64_pkg::*;
#(
  parameter int unsigned FlushWidth = 8,
  parameter int unsigned QueueDepth = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [FlushWidth-1:0]         flush_cnt_i,
  input  logic                          flush_imm_i,
  input  logic                          flush_valid_i,
  output logic                          flush_ready_o,
  input  logic                          r_valid_i,
  input  logic                          r_ready_i,
  input  logic                          r_last_i,
  output logic                          r_valid_o,
  output logic                          r_ready_o,
  output logic                          busy_o,
  output logic                          dropped_o,
  output logic [$clog2(QueueDepth):0]   usage_o
);

  localparam int unsigned AddrW  = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned UsageW = $clog2(QueueDepth) + 1;

  gater_state_e          r_state, w_state_n;
  logic [FlushWidth-1:0] r_cnt, w_cnt_n;
  flush_entry_t          w_entry, w_head;
  logic [FlushWidth-1:0] w_head_cnt;
  logic                  w_full, w_empty, w_push, w_pop;
  logic [AddrW-1:0]      w_fifo_usage;

  assign w_entry    = '{imm: flush_imm_i, cnt: FLUSH_W_MAX'(flush_cnt_i)};
  assign w_head_cnt = FlushWidth'(w_head.cnt);

  // Ready depends only on registered fill state, never on flush_valid_i.
  assign flush_ready_o = !w_full;
  assign w_push        = flush_valid_i && !w_full;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   ($bits(flush_entry_t)),
    .DEPTH        (QueueDepth),
    .dtype        (flush_entry_t)
  ) i_flush_queue (
    .clk_i      (clk_i),
    .rst_ni     (!rst_i),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .usage_o    (w_fifo_usage),
    .data_i     (w_entry),
    .push_i     (w_push),
    .data_o     (w_head),
    .pop_i      (w_pop)
  );

  // The FIFO usage field wraps when full, so the full flag supplies the top value.
  assign usage_o = w_full ? UsageW'(QueueDepth) : {1'b0, w_fifo_usage};
  assign busy_o  = (r_state != IDLE) || !w_empty;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pop     = 1'b0;
    r_valid_o = r_valid_i;
    r_ready_o = r_ready_i;
    dropped_o = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_head_cnt == '0) begin
            // A zero-count request has no effect; retire it.
            w_pop = 1'b1;
          end else if (w_head.imm) begin
            w_pop     = 1'b1;
            w_cnt_n   = w_head_cnt;
            w_state_n = FLUSH;
          end else begin
            w_state_n = ARM;
          end
        end
      end
      ARM: begin
        // Let the in-flight burst complete, then start dropping.
        if (r_valid_i && r_ready_i && r_last_i) begin
          w_pop     = 1'b1;
          w_cnt_n   = w_head_cnt;
          w_state_n = FLUSH;
        end
      end
      FLUSH: begin
        // Swallow every beat; only last beats advance the burst count.
        r_valid_o = 1'b0;
        r_ready_o = 1'b1;
        if (r_valid_i && r_last_i) begin
          dropped_o = 1'b1;
          w_cnt_n   = r_cnt - 1'b1;
          if (r_cnt == FlushWidth'(1)) w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    assert (QueueDepth >= 2 && QueueDepth <= 16)
      else $error("QueueDepth %0d outside 2..16", QueueDepth);
    assert (FlushWidth >= 1 && FlushWidth <= FLUSH_W_MAX)
      else $error("FlushWidth %0d outside 1..%0d", FlushWidth, FLUSH_W_MAX);
  end
`endif

endmodule

// File: tb/tb_idma_desc64_reader_gater_q.sv
module tb_idma_desc64_reader_gater_q;

  localparam int FW = 8;
  localparam int QD = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [FW-1:0]        flush_cnt_i;
  logic                 flush_imm_i;
  logic                 flush_valid_i;
  logic                 flush_ready_o;
  logic                 r_valid_i, r_ready_i, r_last_i;
  logic                 r_valid_o, r_ready_o;
  logic                 busy_o, dropped_o;
  logic [$clog2(QD):0]  usage_o;

  always #5 clk_i = ~clk_i;

  idma_desc64_reader_gater_q #(
    .FlushWidth (FW),
    .QueueDepth (QD)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_cnt_i   (flush_cnt_i),
    .flush_imm_i   (flush_imm_i),
    .flush_valid_i (flush_valid_i),
    .flush_ready_o (flush_ready_o),
    .r_valid_i     (r_valid_i),
    .r_ready_i     (r_ready_i),
    .r_last_i      (r_last_i),
    .r_valid_o     (r_valid_o),
    .r_ready_o     (r_ready_o),
    .busy_o        (busy_o),
    .dropped_o     (dropped_o),
    .usage_o       (usage_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_drops  = 0;
  logic [15:0] exp_q[$];
  int          cur_id, cur_beat;
  bit          cur_pass;
  int          rdy_mode;   // 0: ready=1, 1: random ready, 2: ready=0
  bit          beat_acc, push_acc;

  // One clock cycle: sample at the falling edge, update inputs after the rising edge.
  task automatic step();
    logic [15:0] tag;
    logic [15:0] e;
    beat_acc = 1'b0;
    push_acc = 1'b0;
    @(negedge clk_i);
    tag = {cur_id[7:0], cur_beat[7:0]};
    if (r_valid_o && r_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got beat %h downstream, required none", tag);
      end else begin
        e = exp_q.pop_front();
        if (tag !== e) begin
          n_fail++;
          $display("FAIL beat_order: got beat %h, required %h", tag, e);
        end
      end
    end
    if (r_valid_i && cur_pass) begin
      n_checks++;
      if (r_valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL pass_valid: r_valid_o=%b, required 1 for beat %h", r_valid_o, tag);
      end
    end
    if (r_valid_i && !cur_pass) begin
      n_checks++;
      if (r_valid_o !== 1'b0 || r_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_gate: r_valid_o=%b r_ready_o=%b, required 0/1 for beat %h",
                 r_valid_o, r_ready_o, tag);
      end
    end
    if (dropped_o === 1'b1) n_drops++;
    beat_acc = r_valid_i && r_ready_o;
    push_acc = flush_valid_i && flush_ready_o;
    @(posedge clk_i);
    #1;
    if (push_acc) flush_valid_i = 1'b0;
    case (rdy_mode)
      0:       r_ready_i = 1'b1;
      1:       r_ready_i = 1'($urandom_range(0, 1));
      default: r_ready_i = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_entry(input bit imm, input int cnt);
    int guard;
    flush_imm_i   = imm;
    flush_cnt_i   = cnt[FW-1:0];
    flush_valid_i = 1'b1;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!push_acc && guard < 50);
    n_checks++;
    if (!push_acc) begin
      n_fail++;
      $display("FAIL push_timeout: request not accepted, flush_ready_o=%b", flush_ready_o);
      flush_valid_i = 1'b0;
    end
  endtask

  // Present one burst; beats expected downstream go to the scoreboard first.
  task automatic drive_burst(input int id, input int len, input bit pass,
                             input int push_at = -1, input bit imm = 1'b0, input int cnt = 0);
    int guard;
    cur_pass = pass;
    if (pass) for (int b = 0; b < len; b++) exp_q.push_back({id[7:0], b[7:0]});
    for (int b = 0; b < len; b++) begin
      cur_id    = id;
      cur_beat  = b;
      r_valid_i = 1'b1;
      r_last_i  = (b == len - 1);
      if (b == push_at) begin
        flush_imm_i   = imm;
        flush_cnt_i   = cnt[FW-1:0];
        flush_valid_i = 1'b1;
      end
      guard = 0;
      do begin
        step();
        guard++;
      end while (!beat_acc && guard < 100);
      n_checks++;
      if (!beat_acc) begin
        n_fail++;
        $display("FAIL beat_timeout: burst %0d beat %0d never accepted", id, b);
      end
    end
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    cur_pass  = 1'b1;
  endtask

  task automatic check_end(input string name, input int exp_drops);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d expected beats never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (n_drops != exp_drops) begin
      n_fail++;
      $display("FAIL %s_drops: got %0d dropped_o pulses, required %0d", name, n_drops, exp_drops);
    end
    n_checks++;
    if (busy_o !== 1'b0 || usage_o !== '0) begin
      n_fail++;
      $display("FAIL %s_idle: busy_o=%b usage_o=%0d, required 0/0", name, busy_o, usage_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    r_valid_i = 1'b1;
    r_ready_i = 1'b0;
    #2;
    n_checks++;
    if (usage_o !== '0 || flush_ready_o !== 1'b1 || busy_o !== 1'b0 || dropped_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: usage=%0d ready=%b busy=%b dropped=%b, required 0/1/0/0",
               usage_o, flush_ready_o, busy_o, dropped_o);
    end
    n_checks++;
    if (r_valid_o !== 1'b1 || r_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_passthru: r_valid_o=%b r_ready_o=%b, required 1/0", r_valid_o, r_ready_o);
    end
    r_valid_i = 1'b0;
    r_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(2);
  endtask

  task automatic test_imm_flush_idle();
    n_drops  = 0;
    rdy_mode = 2;
    r_ready_i = 1'b0;
    push_entry(1'b1, 1);
    step();
    #3;
    n_checks++;
    if (r_ready_o !== 1'b1 || r_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL imm_enter_flush: r_ready_o=%b r_valid_o=%b busy=%b, required 1/0/1",
               r_ready_o, r_valid_o, busy_o);
    end
    rdy_mode  = 0;
    r_ready_i = 1'b1;
    drive_burst(10, 3, 1'b0);
    idle(2);
    drive_burst(11, 2, 1'b1);
    idle(3);
    check_end("imm", 1);
  endtask

  task automatic test_deferred_flush();
    n_drops  = 0;
    rdy_mode = 1;
    drive_burst(20, 4, 1'b1, 1, 1'b0, 2);
    drive_burst(21, 4, 1'b0);
    drive_burst(22, 4, 1'b0);
    drive_burst(23, 4, 1'b1);
    rdy_mode = 0;
    idle(3);
    check_end("deferred", 2);
  endtask

  task automatic test_zero_entry();
    n_drops  = 0;
    rdy_mode = 0;
    push_entry(1'b0, 0);
    push_entry(1'b0, 1);
    #3;
    n_checks++;
    if (usage_o !== 1) begin
      n_fail++;
      $display("FAIL push_pop_usage: usage_o=%0d, required 1", usage_o);
    end
    idle(2);
    drive_burst(30, 3, 1'b1);
    drive_burst(31, 3, 1'b0);
    drive_burst(32, 3, 1'b1);
    idle(3);
    check_end("zero", 1);
  endtask

  task automatic test_queue_full();
    n_drops  = 0;
    rdy_mode = 0;
    for (int i = 1; i <= QD; i++) begin
      push_entry(1'b0, 1);
      #3;
      n_checks++;
      if (usage_o !== i) begin
        n_fail++;
        $display("FAIL usage_fill: usage_o=%0d, required %0d", usage_o, i);
      end
    end
    n_checks++;
    if (flush_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: flush_ready_o=%b, required 0", flush_ready_o);
    end
    flush_imm_i   = 1'b0;
    flush_cnt_i   = 1;
    flush_valid_i = 1'b1;
    idle(3);
    #3;
    n_checks++;
    if (flush_ready_o !== 1'b0 || usage_o !== QD) begin
      n_fail++;
      $display("FAIL full_stall: flush_ready_o=%b usage_o=%0d, required 0/%0d",
               flush_ready_o, usage_o, QD);
    end
    rdy_mode = 1;
    for (int k = 0; k < 10; k++) drive_burst(40 + k, 3, (k % 2) == 0);
    rdy_mode = 0;
    idle(3);
    n_checks++;
    if (flush_valid_i !== 1'b0) begin
      n_fail++;
      $display("FAIL stalled_push: fifth request never accepted");
      flush_valid_i = 1'b0;
    end
    check_end("full", 5);
  endtask

  task automatic test_reset_mid_flush();
    n_drops   = 0;
    rdy_mode  = 2;
    r_ready_i = 1'b0;
    push_entry(1'b1, 3);
    push_entry(1'b0, 1);
    push_entry(1'b0, 1);
    #3;
    n_checks++;
    if (usage_o !== 2 || r_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: usage_o=%0d r_ready_o=%b, required 2/1", usage_o, r_ready_o);
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (r_ready_o !== 1'b0 || usage_o !== '0 || flush_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL in_reset: r_ready_o=%b usage=%0d ready=%b busy=%b, required 0/0/1/0",
               r_ready_o, usage_o, flush_ready_o, busy_o);
    end
    step();
    rst_i = 1'b0;
    #3;
    n_checks++;
    if (r_ready_o !== 1'b0 || usage_o !== '0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: r_ready_o=%b usage=%0d busy=%b, required 0/0/0",
               r_ready_o, usage_o, busy_o);
    end
    rdy_mode  = 0;
    r_ready_i = 1'b1;
    idle(1);
    drive_burst(50, 2, 1'b1);
    idle(3);
    check_end("rst_flush", 0);
  endtask

  initial begin
    rst_i         = 1'b1;
    flush_valid_i = 1'b0;
    flush_imm_i   = 1'b0;
    flush_cnt_i   = '0;
    r_valid_i     = 1'b0;
    r_ready_i     = 1'b1;
    r_last_i      = 1'b0;
    cur_pass      = 1'b1;
    cur_id        = 0;
    cur_beat      = 0;
    rdy_mode      = 0;
    test_reset();
    test_imm_flush_idle();
    test_deferred_flush();
    test_zero_entry();
    test_queue_full();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
